vram_arbiter: RTL

- Time-slot arbiter for the single-port video/system RAM, shared by two requesters:
  - the video controller's pixel/roller-RAM fetch path;
  - the CPU memory bus (req/ack).
- Splits each pixel period (PIX_DIV clk_sys cycles between ce_pix strobes) into fixed slots. The video fetch gets a guaranteed slot; the CPU uses the rest.
- Sits between video_controller, the CPU bus interface and the RAM macro (registered output, 1-cycle read latency).

---
 rtl/vram_arb_pkg.sv | 25 ++
 rtl/vram_slot_timer.sv | 42 ++++
 rtl/vram_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/vram_arb_pkg.sv
// vram_arb_pkg: shared types and slot helpers for the VRAM time-slot arbiter. Rev 1.0
`default_nettype none

package vram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    ACK   = 2'd2
  } cpu_state_t;

  localparam int PIX_DIV_DEF = 4;
  localparam int SLOT_W      = $clog2(PIX_DIV_DEF);

  function automatic logic is_video_slot(input int slot, input int pix_div);
    return slot == pix_div - 1;
  endfunction

  function automatic logic is_cpu_slot(input int slot, input int pix_div);
    return slot < pix_div - 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vram_slot_timer.sv
// vram_slot_timer: pixel-period slot counter with ce_pix realignment and sticky sync error. Rev 1.0
`default_nettype none

module vram_slot_timer
  import vram_arb_pkg::*;
#(
  parameter int PIX_DIV   = PIX_DIV_DEF,
  parameter int SLOT_BITS = $clog2(PIX_DIV)
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  input  logic                 ce_pix,
  output logic [SLOT_BITS-1:0] slot,
  output logic                 video_slot,
  output logic                 sync_err
);

  logic [SLOT_BITS-1:0] slot_cnt;
  logic                 locked;

  // A strobe always defines slot 0, even when it arrives out of phase.
  assign slot       = ce_pix ? '0 : slot_cnt;
  assign video_slot = is_video_slot(int'(slot), PIX_DIV);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      slot_cnt <= '0;
      locked   <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      slot_cnt <= slot + SLOT_BITS'(1);
      if (ce_pix) begin
        locked <= 1'b1;
        if (locked && slot_cnt != '0)
          sync_err <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/vram_arbiter.sv
// vram_arbiter: video/CPU time-slot arbiter for the shared single-port RAM. Rev 1.0
// Optional VRAM_ARB_BLANK_EN: during vid_blank the video slot is also given to the CPU.
`default_nettype none

module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int ADDR_W  = 17,
  parameter int DATA_W  = 8,
  parameter int PIX_DIV = PIX_DIV_DEF
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ce_pix,
  input  logic              vid_blank,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_din,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_q,
  output logic              sync_err
);

  localparam int SLOT_BITS = $clog2(PIX_DIV);

  logic [SLOT_BITS-1:0] slot;
  logic                 video_slot;
  logic                 video_fetch;
  logic                 cpu_slot_ok;
  logic                 cpu_issue;
  logic                 vid_fetch_q;
  logic                 rd_pending;
  cpu_state_t           state;
  cpu_state_t           state_next;
  logic [ADDR_W-1:0]    addr_q;
  logic [DATA_W-1:0]    wdata_q;
  logic [DATA_W-1:0]    vid_hold;
  logic [DATA_W-1:0]    rdata_hold;

  vram_slot_timer #(
    .PIX_DIV   (PIX_DIV),
    .SLOT_BITS (SLOT_BITS)
  ) u_slot_timer (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .ce_pix     (ce_pix),
    .slot       (slot),
    .video_slot (video_slot),
    .sync_err   (sync_err)
  );

`ifdef VRAM_ARB_BLANK_EN
  assign video_fetch = video_slot && !vid_blank;
  assign cpu_slot_ok = is_cpu_slot(int'(slot), PIX_DIV) || vid_blank;
`else
  logic unused_blank;
  assign unused_blank = vid_blank;
  assign video_fetch  = video_slot;
  assign cpu_slot_ok  = is_cpu_slot(int'(slot), PIX_DIV);
`endif

  always_comb begin
    state_next = state;
    cpu_issue  = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req && cpu_slot_ok) begin
          state_next = ISSUE;
          cpu_issue  = 1'b1;
        end
      end
      ISSUE:   state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // RAM port: the bus is driven only in an issue or fetch cycle; otherwise the address holds.
  always_comb begin
    ram_addr  = addr_q;
    ram_we    = 1'b0;
    ram_wdata = wdata_q;
    if (!reset) begin
      if (cpu_issue) begin
        ram_addr  = cpu_addr;
        ram_we    = cpu_we;
        ram_wdata = cpu_wdata;
      end else if (video_fetch) begin
        ram_addr = vid_addr;
      end
    end
  end

  assign cpu_ack   = (state == ISSUE) && !reset;
  assign cpu_rdata = (cpu_ack && rd_pending) ? ram_q : rdata_hold;
  assign vid_din   = vid_fetch_q ? ram_q : vid_hold;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state       <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      vid_hold    <= '0;
      rdata_hold  <= '0;
      vid_fetch_q <= 1'b0;
      rd_pending  <= 1'b0;
    end else begin
      state       <= state_next;
      addr_q      <= ram_addr;
      wdata_q     <= ram_wdata;
      vid_fetch_q <= video_fetch;
      if (vid_fetch_q)
        vid_hold <= ram_q;
      if (cpu_issue)
        rd_pending <= !cpu_we;
      if (cpu_ack && rd_pending)
        rdata_hold <= ram_q;
    end
  end

endmodule

`default_nettype wire
